// File: rtl/hazard_control_unit.sv
// Hazard and pipeline-control unit for the 5-stage core: load-use and branch-operand
// stalls, taken-branch flush, data-memory wait freeze with timeout, and saturating statistics.
module hazard_control_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] Rs1_i,
  input  logic [REG_ADDR_W-1:0] Rs2_i,
  input  logic                  UseRs1_i,
  input  logic                  UseRs2_i,
  input  logic                  Branch_i,
  input  logic                  BranchTaken_i,
  input  logic                  EX_MemRead_i,
  input  logic                  EX_RegWrite_i,
  input  logic [REG_ADDR_W-1:0] EX_Rd_i,
  input  logic                  MEM_MemRead_i,
  input  logic [REG_ADDR_W-1:0] MEM_Rd_i,
  input  logic                  DmemReq_i,
  input  logic                  DmemReady_i,
  output logic                  NoOp_o,
  output logic                  Stall_o,
  output logic                  PCWrite_o,
  output logic                  Flush_o,
  output logic                  Freeze_o,
  output logic                  MemErr_o,
  output logic [CNT_W-1:0]      StallCnt_o,
  output logic [CNT_W-1:0]      FlushCnt_o
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_VAL = WCNT_W'(MEM_TIMEOUT);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t              state_reg, state_next;
  logic [WCNT_W-1:0]   wcnt_reg, wcnt_next;
  logic                mem_err_reg, mem_err_next;
  logic [CNT_W-1:0]    stall_cnt_reg, flush_cnt_reg;

  logic lu_hazard, br_hazard, data_stall, timeout_hit, freeze_cond, stall_event;

  // x0 is hard-wired zero, so a producer targeting it never creates a dependency
  function automatic logic hit(input logic [REG_ADDR_W-1:0] rd,
                               input logic [REG_ADDR_W-1:0] rs,
                               input logic                  en);
    return en && (rd != '0) && (rd == rs);
  endfunction

  assign lu_hazard = EX_MemRead_i &&
                     (hit(EX_Rd_i, Rs1_i, UseRs1_i) || hit(EX_Rd_i, Rs2_i, UseRs2_i));
  assign br_hazard = Branch_i &&
                     ((EX_RegWrite_i && (hit(EX_Rd_i, Rs1_i, UseRs1_i) ||
                                         hit(EX_Rd_i, Rs2_i, UseRs2_i))) ||
                      (MEM_MemRead_i && (hit(MEM_Rd_i, Rs1_i, UseRs1_i) ||
                                         hit(MEM_Rd_i, Rs2_i, UseRs2_i))));
  assign data_stall  = lu_hazard || br_hazard;
  assign timeout_hit = (state_reg == ST_WAIT) && (wcnt_reg == TIMEOUT_VAL);
  assign freeze_cond = DmemReq_i && !DmemReady_i && !timeout_hit;
  assign stall_event = rst_i && data_stall && !freeze_cond;

  always_comb begin
    state_next   = state_reg;
    wcnt_next    = wcnt_reg;
    mem_err_next = mem_err_reg;
    NoOp_o       = 1'b0;
    Stall_o      = 1'b0;
    PCWrite_o    = 1'b1;
    Flush_o      = 1'b0;
    Freeze_o     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (DmemReq_i && !DmemReady_i) begin
          state_next = ST_WAIT;
          wcnt_next  = WCNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (DmemReady_i) begin
          state_next = ST_IDLE;
          wcnt_next  = '0;
        end else if (timeout_hit) begin
          state_next   = ST_IDLE;
          wcnt_next    = '0;
          mem_err_next = 1'b1;
        end else begin
          wcnt_next = wcnt_reg + WCNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        wcnt_next  = '0;
      end
    endcase

    // Freeze holds every register, so no bubble is needed on top of it
    if (rst_i) begin
      if (freeze_cond) begin
        Freeze_o  = 1'b1;
        PCWrite_o = 1'b0;
      end else if (data_stall) begin
        NoOp_o    = 1'b1;
        Stall_o   = 1'b1;
        PCWrite_o = 1'b0;
      end else begin
        Flush_o = Branch_i && BranchTaken_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg     <= ST_IDLE;
      wcnt_reg      <= '0;
      mem_err_reg   <= 1'b0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      wcnt_reg    <= wcnt_next;
      mem_err_reg <= mem_err_next;
      if (stall_event && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (Flush_o && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

  assign MemErr_o   = mem_err_reg;
  assign StallCnt_o = stall_cnt_reg;
  assign FlushCnt_o = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with small counters and a short memory timeout.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] rs1, rs2, ex_rd, mem_rd;
  logic       use_rs1, use_rs2, branch, taken, ex_mem_read, ex_reg_write, mem_mem_read;
  logic       dmem_req, dmem_ready;
  logic       noop, stall, pc_write, flush, freeze, mem_err;
  logic [1:0] stall_cnt, flush_cnt;
  logic [4:0] ctl;

  int errors = 0;
  int checks = 0;

  // ctl = {NoOp, Stall, PCWrite, Flush, Freeze}
  localparam logic [4:0] C_IDLE   = 5'b00100;
  localparam logic [4:0] C_STALL  = 5'b11000;
  localparam logic [4:0] C_FLUSH  = 5'b00110;
  localparam logic [4:0] C_FREEZE = 5'b00001;

  assign ctl = {noop, stall, pc_write, flush, freeze};

  hazard_control_unit #(.REG_ADDR_W(5), .CNT_W(2), .MEM_TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .Rs1_i(rs1), .Rs2_i(rs2), .UseRs1_i(use_rs1), .UseRs2_i(use_rs2),
    .Branch_i(branch), .BranchTaken_i(taken),
    .EX_MemRead_i(ex_mem_read), .EX_RegWrite_i(ex_reg_write), .EX_Rd_i(ex_rd),
    .MEM_MemRead_i(mem_mem_read), .MEM_Rd_i(mem_rd),
    .DmemReq_i(dmem_req), .DmemReady_i(dmem_ready),
    .NoOp_o(noop), .Stall_o(stall), .PCWrite_o(pc_write), .Flush_o(flush),
    .Freeze_o(freeze), .MemErr_o(mem_err), .StallCnt_o(stall_cnt), .FlushCnt_o(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1 = 0; rs2 = 0; ex_rd = 0; mem_rd = 0;
    use_rs1 = 0; use_rs2 = 0; branch = 0; taken = 0;
    ex_mem_read = 0; ex_reg_write = 0; mem_mem_read = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    tick();
    rst = 1'b1;
    #2;
  endtask

  task automatic set_lu();
    ex_mem_read = 1; ex_rd = 5; rs1 = 5; use_rs1 = 1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    set_lu();
    branch = 1; taken = 1; dmem_req = 1;
    #2;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_IDLE); end
    tick();
    checks++; if ({mem_err, stall_cnt, flush_cnt} !== 5'b0) begin errors++;
      $display("FAIL reset_state got err=%b sc=%0d fc=%0d exp 0", mem_err, stall_cnt, flush_cnt); end
    rst = 1'b1;
    clear_inputs();
    #2;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL reset_idle got=%b exp=%b", ctl, C_IDLE); end
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    do_reset();
    set_lu();
    #2;
    checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL lu_stall got=%b exp=%b", ctl, C_STALL); end
    checks++; if (stall_cnt !== 2'd0) begin errors++; $display("FAIL lu_cnt0 got=%0d exp=0", stall_cnt); end
    tick();
    clear_inputs();
    #2;
    checks++; if (stall_cnt !== 2'd1) begin errors++; $display("FAIL lu_cnt1 got=%0d exp=1", stall_cnt); end
    ex_mem_read = 1; ex_rd = 0; rs1 = 0; use_rs1 = 1;
    #2;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL lu_x0 got=%b exp=%b", ctl, C_IDLE); end
    ex_rd = 9; rs2 = 9; use_rs2 = 0;
    #2;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL lu_unused got=%b exp=%b", ctl, C_IDLE); end
    use_rs2 = 1;
    #2;
    checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL lu_rs2 got=%b exp=%b", ctl, C_STALL); end
    tick();
    clear_inputs();
    #2;
    checks++; if (stall_cnt !== 2'd2) begin errors++; $display("FAIL lu_cnt2 got=%0d exp=2", stall_cnt); end
    $display("test_load_use done");
  endtask

  task automatic test_load_branch();
    do_reset();
    branch = 1; rs2 = 7; use_rs2 = 1;
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 7;
    #2;
    checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL lb_stall1 got=%b exp=%b", ctl, C_STALL); end
    tick();
    ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0;
    mem_mem_read = 1; mem_rd = 7;
    #2;
    checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL lb_stall2 got=%b exp=%b", ctl, C_STALL); end
    tick();
    mem_mem_read = 0; mem_rd = 0;
    #2;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL lb_release got=%b exp=%b", ctl, C_IDLE); end
    checks++; if (stall_cnt !== 2'd2) begin errors++; $display("FAIL lb_cnt got=%0d exp=2", stall_cnt); end
    ex_reg_write = 1; ex_rd = 7;
    #2;
    checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL alu_br_stall got=%b exp=%b", ctl, C_STALL); end
    tick();
    ex_reg_write = 0; ex_rd = 0; mem_rd = 7; mem_mem_read = 0;
    #2;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL alu_br_one got=%b exp=%b", ctl, C_IDLE); end
    checks++; if (stall_cnt !== 2'd3) begin errors++; $display("FAIL alu_br_cnt got=%0d exp=3", stall_cnt); end
    $display("test_load_branch done");
  endtask

  task automatic test_flush();
    do_reset();
    branch = 1; taken = 1;
    #2;
    checks++; if (ctl !== C_FLUSH) begin errors++; $display("FAIL flush_ctl got=%b exp=%b", ctl, C_FLUSH); end
    tick();
    clear_inputs();
    taken = 1;
    #2;
    checks++; if (flush_cnt !== 2'd1) begin errors++; $display("FAIL flush_cnt got=%0d exp=1", flush_cnt); end
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL flush_nobranch got=%b exp=%b", ctl, C_IDLE); end
    branch = 1; ex_reg_write = 1; ex_rd = 3; rs1 = 3; use_rs1 = 1;
    #2;
    checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL flush_bh got=%b exp=%b", ctl, C_STALL); end
    tick();
    clear_inputs();
    #2;
    checks++; if ({flush_cnt, stall_cnt} !== 4'b0101) begin errors++;
      $display("FAIL flush_bh_cnt got fc=%0d sc=%0d exp fc=1 sc=1", flush_cnt, stall_cnt); end
    $display("test_flush done");
  endtask

  task automatic test_mem_wait();
    do_reset();
    dmem_req = 1; dmem_ready = 1;
    #2;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL mem_ready_same got=%b exp=%b", ctl, C_IDLE); end
    dmem_ready = 0;
    set_lu();
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (ctl !== C_FREEZE) begin errors++; $display("FAIL mem_freeze%0d got=%b exp=%b", i, ctl, C_FREEZE); end
      tick();
    end
    dmem_ready = 1;
    #2;
    checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL mem_ready_stall got=%b exp=%b", ctl, C_STALL); end
    checks++; if (stall_cnt !== 2'd0) begin errors++; $display("FAIL mem_stall_cnt got=%0d exp=0", stall_cnt); end
    tick();
    clear_inputs();
    #2;
    checks++; if ({stall_cnt, mem_err} !== 3'b010) begin errors++;
      $display("FAIL mem_after got sc=%0d err=%b exp sc=1 err=0", stall_cnt, mem_err); end
    $display("test_mem_wait done");
  endtask

  task automatic timeout_run(input string tag);
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++; if (ctl !== C_FREEZE) begin errors++; $display("FAIL %s_freeze%0d got=%b exp=%b", tag, i, ctl, C_FREEZE); end
      tick();
    end
    #2;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL %s_release got=%b exp=%b", tag, ctl, C_IDLE); end
    tick();
    dmem_req = 0;
    #2;
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL %s_err got=%b exp=1", tag, mem_err); end
  endtask

  task automatic test_timeout();
    do_reset();
    timeout_run("to");
    tick(); tick();
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b exp=1", mem_err); end
    set_lu();
    tick();
    clear_inputs();
    dmem_req = 1;
    tick(); tick();
    rst = 1'b0;
    #2;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL to_rst_ctl got=%b exp=%b", ctl, C_IDLE); end
    tick();
    rst = 1'b1;
    dmem_req = 0;
    #2;
    checks++; if ({mem_err, stall_cnt, flush_cnt} !== 5'b0) begin errors++;
      $display("FAIL to_rst_state got err=%b sc=%0d fc=%0d exp 0", mem_err, stall_cnt, flush_cnt); end
    timeout_run("to2");
    $display("test_timeout done");
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    do_reset();
    set_lu();
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp_cnt = (i > 3) ? 2'd3 : 2'(i);
      checks++; if (stall_cnt !== exp_cnt) begin errors++;
        $display("FAIL sat_%0d got=%0d exp=%0d", i, stall_cnt, exp_cnt); end
    end
    clear_inputs();
    branch = 1; taken = 1;
    for (int i = 1; i <= 4; i++) tick();
    checks++; if (flush_cnt !== 2'd3) begin errors++; $display("FAIL sat_flush got=%0d exp=3", flush_cnt); end
    clear_inputs();
    $display("test_saturation done");
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_load_branch();
    test_flush();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
